pc_sequencer: RTL and testbench

Multicycle instruction-flow controller for the MIPS datapath. Owns the program counter and instruction register, runs the fetch handshake with instruction memory, and on each instruction completion selects the next PC: sequential, taken branch, 26-bit jump target (upper PC nibble spliced with the shifted instruction index), register jump, or exception vector. It sits between the control unit (which executes the held instruction and reports completion) and the memory port.

---
 rtl/pc_sequencer_pkg.sv | 30 +++
 rtl/pc_sequencer_jtarget_gen.sv | 13 +
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types and constants for the pc_sequencer slice.
//   state_e    : controller phase (IDLE / FETCH / EXEC)
//   redirect_e : next-PC selector driven by the control unit
//   cause_e    : encoding reported on the cause output
//   PC_STEP    : sequential instruction stride in bytes
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RD_SEQ    = 2'b00,
        RD_BRANCH = 2'b01,
        RD_JUMP   = 2'b10,
        RD_JREG   = 2'b11
    } redirect_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EXTERNAL = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } cause_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_sequencer_jtarget_gen.sv
// jtarget_gen: combinational J-type target builder.
//   i_pc4_hi [3:0]  : upper nibble of pc+4
//   i_index  [25:0] : instruction index field
//   o_target [31:0] : {pc4[31:28], index, 2'b00}
module jtarget_gen (
    input  logic [3:0]  i_pc4_hi,
    input  logic [25:0] i_index,
    output logic [31:0] o_target
);

    assign o_target = {i_pc4_hi, i_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle instruction-flow controller. Owns PC and IR,
// runs the fetch handshake and selects the next PC on completion.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   fetch_req / fetch_ack : fetch handshake, instr valid with fetch_ack
//   pc, ir, ir_valid      : program counter, held instruction, hold flag
//   done, redirect        : completion and next-PC kind from control unit
//   branch_taken, rs_val  : branch result / register target, sampled with done
//   exc                   : external exception request (EXEC only)
//   epc, cause            : faulting PC and last exception cause
// Build option: PC_SEQ_ALIGN_CHECK_EN enables the misaligned jump-register
// check (cause 3); without it rs_val is loaded verbatim.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0080,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        fetch_req,
    input  logic        fetch_ack,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        done,
    input  logic [1:0]  redirect,
    input  logic        branch_taken,
    input  logic [31:0] rs_val,
    input  logic        exc,
    output logic [31:0] epc,
    output logic [1:0]  cause
);

    // Counter holds the number of ack-less FETCH cycles already elapsed,
    // so it only needs to reach FETCH_TIMEOUT-1.
    localparam int unsigned TW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
    localparam logic [TW-1:0] TLAST = (FETCH_TIMEOUT == 0) ? '0 : TW'(FETCH_TIMEOUT - 1);

    state_e        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_ir;
    logic          r_ir_valid;
    logic          r_fetch_req;
    logic [31:0]   r_epc;
    cause_e        r_cause;
    logic [TW-1:0] r_tcnt;

    logic [31:0]   w_pc4;
    logic [31:0]   w_br_off;
    logic [31:0]   w_jtarget;
    logic [31:0]   w_next_pc;
    logic          w_timeout;
    logic          w_misalign;

    assign w_pc4    = r_pc + PC_STEP;
    assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

    jtarget_gen u_jtarget (
        .i_pc4_hi (w_pc4[31:28]),
        .i_index  (r_ir[25:0]),
        .o_target (w_jtarget)
    );

    always_comb begin
        w_next_pc = w_pc4;
        case (redirect_e'(redirect))
            RD_SEQ:    w_next_pc = w_pc4;
            RD_BRANCH: if (branch_taken) w_next_pc = w_pc4 + w_br_off;
            RD_JUMP:   w_next_pc = w_jtarget;
            RD_JREG:   w_next_pc = rs_val;
            default:   w_next_pc = w_pc4;
        endcase
    end

`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign w_misalign = (redirect_e'(redirect) == RD_JREG) && (rs_val[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Current FETCH cycle is the last allowed one when TLAST cycles have passed.
    assign w_timeout = (FETCH_TIMEOUT != 0) && (r_tcnt == TLAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_VECTOR;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_req <= 1'b0;
            r_epc       <= '0;
            r_cause     <= CAUSE_NONE;
            r_tcnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_FETCH;
                    r_fetch_req <= 1'b1;
                    r_tcnt      <= '0;
                end
                ST_FETCH: begin
                    if (fetch_ack) begin
                        r_ir        <= instr;
                        r_ir_valid  <= 1'b1;
                        r_fetch_req <= 1'b0;
                        r_state     <= ST_EXEC;
                    end else if (w_timeout) begin
                        // Refetch from the vector; stay in FETCH with a fresh count.
                        r_epc   <= r_pc;
                        r_pc    <= EXC_VECTOR;
                        r_cause <= CAUSE_TIMEOUT;
                        r_tcnt  <= '0;
                    end else if (FETCH_TIMEOUT != 0) begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                ST_EXEC: begin
                    if (exc || (done && w_misalign)) begin
                        r_epc   <= r_pc;
                        r_pc    <= EXC_VECTOR;
                        r_cause <= exc ? CAUSE_EXTERNAL : CAUSE_MISALIGN;
                    end else if (done) begin
                        r_pc <= w_next_pc;
                    end
                    if (exc || done) begin
                        r_ir_valid  <= 1'b0;
                        r_fetch_req <= 1'b1;
                        r_tcnt      <= '0;
                        r_state     <= ST_FETCH;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_fetch_req <= 1'b0;
                    r_ir_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_req = r_fetch_req;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign epc       = r_epc;
    assign cause     = r_cause;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized bench for pc_sequencer, checked
// each cycle against a behavioural model of the instruction flow.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0080;
    localparam int          TO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req;
    logic        fetch_ack;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        done;
    logic [1:0]  redirect;
    logic        branch_taken;
    logic [31:0] rs_val;
    logic        exc;
    logic [31:0] epc;
    logic [1:0]  cause;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 = waiting to start, 1 = fetching, 2 = holding instruction.
    int          m_phase;
    int          m_wait;
    logic [31:0] m_pc, m_ir, m_epc;
    int          m_cause;

    pc_sequencer #(
        .RESET_VECTOR  (RV),
        .EXC_VECTOR    (EV),
        .FETCH_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetch_req    (fetch_req),
        .fetch_ack    (fetch_ack),
        .instr        (instr),
        .pc           (pc),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .done         (done),
        .redirect     (redirect),
        .branch_taken (branch_taken),
        .rs_val       (rs_val),
        .exc          (exc),
        .epc          (epc),
        .cause        (cause)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_wait = 0;
        m_pc = RV; m_ir = '0; m_epc = '0; m_cause = 0;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] iw);
        logic [31:0] nxt;
        logic [31:0] off;
        nxt = cur + 32'd4;
        case (redirect)
            2'd1: begin
                off = 32'(signed'(iw[15:0]));
                if (branch_taken) nxt = nxt + off * 32'd4;
            end
            2'd2: nxt = (nxt & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
            2'd3: nxt = rs_val;
            default: ;
        endcase
        return nxt;
    endfunction

    task automatic model_step();
        bit bad_align;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_phase == 0) begin
            m_phase = 1; m_wait = 0;
        end else if (m_phase == 1) begin
            if (fetch_ack) begin
                m_ir = instr; m_phase = 2;
            end else if (m_wait + 1 == TO) begin
                m_epc = m_pc; m_pc = EV; m_cause = 2; m_wait = 0;
            end else begin
                m_wait++;
            end
        end else begin
            bad_align = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            bad_align = (redirect == 2'd3) && (rs_val % 4 != 0);
`endif
            if (exc) begin
                m_epc = m_pc; m_pc = EV; m_cause = 1;
            end else if (done && bad_align) begin
                m_epc = m_pc; m_pc = EV; m_cause = 3;
            end else if (done) begin
                m_pc = model_next(m_pc, m_ir);
            end
            if (exc || done) begin
                m_phase = 1; m_wait = 0;
            end
        end
    endtask

    task automatic compare();
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("ir_valid", 32'(ir_valid), 32'(m_phase == 2));
        chk("fetch_req", 32'(fetch_req), 32'(m_phase == 1));
        chk("epc", epc, m_epc);
        chk("cause", 32'(cause), 32'(m_cause));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run_instr(input logic [31:0] iw, input logic [1:0] rd,
                             input logic tk, input logic [31:0] rs, input logic ex);
        int n;
        n = 0;
        while (!fetch_req && n < 20) begin
            tick();
            n++;
        end
        if (!fetch_req) begin
            chk("fetch_req_wait", 32'(fetch_req), 32'd1);
        end
        fetch_ack = 1'b1; instr = iw;
        tick();
        fetch_ack = 1'b0;
        done = 1'b1; redirect = rd; branch_taken = tk; rs_val = rs; exc = ex;
        tick();
        done = 1'b0; exc = 1'b0; redirect = 2'd0; branch_taken = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        run_instr($urandom, 2'd3, 1'b0, v, 1'b0);
    endtask

    initial begin
        bit low_ack;
        reset_n = 1'b0; fetch_ack = 1'b0; instr = '0; done = 1'b0;
        redirect = 2'd0; branch_taken = 1'b0; rs_val = '0; exc = 1'b0;
        #3;
        model_reset();
        compare();
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("first_fetch_req", 32'(fetch_req), 32'd1);

        run_instr(32'h2002_0005, 2'd0, 1'b0, 32'h0, 1'b0);
        chk("seq_ir", ir, 32'h2002_0005);
        chk("seq_pc", pc, 32'h0000_0004);
        chk("seq_refetch", 32'(fetch_req), 32'd1);

        set_pc(32'h8000_0010);
        run_instr(32'h1000_FFFE, 2'd1, 1'b1, 32'h0, 1'b0);
        chk("branch_taken_pc", pc, 32'h8000_000C);
        set_pc(32'h8000_0010);
        run_instr(32'h1000_FFFE, 2'd1, 1'b0, 32'h0, 1'b0);
        chk("branch_not_taken_pc", pc, 32'h8000_0014);

        set_pc(32'hF000_0000);
        run_instr(32'h0800_0040, 2'd2, 1'b0, 32'h0, 1'b0);
        chk("jump_pc", pc, 32'hF000_0100);
        set_pc(32'hFFFF_FFFC);
        run_instr(32'h0000_0000, 2'd0, 1'b0, 32'h0, 1'b0);
        chk("seq_wrap_pc", pc, 32'h0000_0000);

        set_pc(32'h0000_0040);
        run_instr(32'h1234_5678, 2'd3, 1'b0, 32'h0000_0400, 1'b1);
        chk("exc_epc", epc, 32'h0000_0040);
        chk("exc_pc", pc, EV);
        chk("exc_cause", 32'(cause), 32'd1);

        set_pc(32'h0000_0100);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("timeout_not_yet_cause", 32'(cause), 32'd1);
        chk("timeout_not_yet_pc", pc, 32'h0000_0100);
        tick();
        chk("timeout_cause", 32'(cause), 32'd2);
        chk("timeout_pc", pc, EV);
        chk("timeout_epc", epc, 32'h0000_0100);
        for (int i = 0; i < TO - 1; i++) tick();
        fetch_ack = 1'b1; instr = 32'hCAFE_0001;
        tick();
        fetch_ack = 1'b0;
        chk("late_ack_valid", 32'(ir_valid), 32'd1);
        chk("late_ack_ir", ir, 32'hCAFE_0001);
        chk("late_ack_pc", pc, EV);
        done = 1'b1; redirect = 2'd0;
        tick();
        done = 1'b0;

        set_pc(32'h0000_0200);
        run_instr(32'h0000_0008, 2'd3, 1'b0, 32'h0000_0102, 1'b0);
`ifdef PC_SEQ_ALIGN_CHECK_EN
        chk("jr_misalign_cause", 32'(cause), 32'd3);
        chk("jr_misalign_pc", pc, EV);
        chk("jr_misalign_epc", epc, 32'h0000_0200);
`else
        chk("jr_verbatim_pc", pc, 32'h0000_0102);
        chk("jr_verbatim_cause", 32'(cause), 32'd2);
`endif

        // Async reset in the middle of a cycle.
        fetch_ack = 1'b1; instr = $urandom;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pc", pc, RV);
        chk("async_rst_cause", 32'(cause), 32'd0);
        compare();
        fetch_ack = 1'b0;
        tick();
        reset_n = 1'b1;

        low_ack = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 150 == 0) low_ack = ($urandom_range(0, 2) == 0);
            fetch_ack    = low_ack ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
            instr        = $urandom;
            done         = $urandom_range(0, 1);
            exc          = ($urandom_range(0, 15) == 0);
            redirect     = 2'($urandom_range(0, 3));
            branch_taken = $urandom_range(0, 1);
            rs_val       = $urandom;
            if ($urandom_range(0, 1) == 0) rs_val[1:0] = 2'b00;
            if ($urandom_range(0, 599) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                compare();
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
